// File: rtl/pe_pkg.sv
// Shared types and helpers for the Jacobi processing element.
// State encoding plus a constant log2 used to size the adder carry.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        UPDATE,
        READ
    } state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_jacobi_serial_sum.sv
// Bit-serial adder column: NBR lanes plus a registered multi-bit carry.
// Emits one sum bit per enabled cycle, LSB-first.
module serial_sum #(
    parameter int NBR = 4,
    parameter int SH  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [NBR-1:0] bits,
    output logic           sum_bit
);

    logic [SH:0]   carry;
    logic [SH+1:0] total;

    always_comb begin
        total = {1'b0, carry};
        for (int i = 0; i < NBR; i++) begin
            total = total + {{(SH + 1){1'b0}}, bits[i]};
        end
    end

    assign sum_bit = total[0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            carry <= '0;
        end else if (en) begin
            carry <= total[SH+1:1];
        end
    end

endmodule

// File: rtl/pe_jacobi.sv
// One Jacobi relaxation element: serial neighbour sum, average,
// residue against the previous solution, and a daisy-chain readout.
module pe_jacobi
    import pe_pkg::*;
#(
    parameter int             W   = 8,
    parameter int             NBR = 4,
    parameter logic [W-1:0]   TOL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           read,
    input  logic [NBR-1:0] nbr_in,
    input  logic           neighbor_solution,
    output logic           solution,
    output logic           residue,
    output logic           busy,
    output logic           done,
    output logic           conv
);

    localparam int SH = log2(NBR);
    localparam int SW = W + SH;
    localparam int CW = log2(SW + 1);

    state_t         state;
    state_t         nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   sol;
    logic [W:0]     res;
    logic [SW-1:0]  acc;
    logic           in_data;
    logic [NBR-1:0] lanes;
    logic           sum_bit;
    logic [W-1:0]   avg;
    logic [W:0]     res_new;
    logic [W:0]     mag;

    assign in_data = (cnt < CW'(W));
    assign lanes   = in_data ? nbr_in : '0;

    serial_sum #(
        .NBR(NBR),
        .SH (SH)
    ) u_sum (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state == SUM),
        .bits   (lanes),
        .sum_bit(sum_bit)
    );

    // Dropping the low SH bits is the divide by NBR.
    assign avg     = acc[SW-1:SH];
    assign res_new = {1'b0, avg} - {1'b0, sol};
    assign mag     = res_new[W] ? (~res_new + 1'b1) : res_new;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (read) begin
                    nxt = READ;
                end else if (start) begin
                    nxt = SUM;
                end
            end
            SUM: begin
                if (cnt == CW'(SW - 1)) begin
                    nxt = UPDATE;
                end
            end
            UPDATE: nxt = IDLE;
            READ: begin
                if (!read) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sol   <= '0;
            res   <= '0;
            acc   <= '0;
            done  <= 1'b0;
            conv  <= 1'b0;
        end else begin
            state <= nxt;
            done  <= (state == UPDATE);
            unique case (state)
                IDLE: cnt <= '0;
                SUM: begin
                    cnt <= cnt + 1'b1;
                    acc <= {sum_bit, acc[SW-1:1]};
                    res <= {res[W], res[W:1]};
                    if (in_data) begin
                        sol <= {sol[0], sol[W-1:1]};
                    end
                end
                UPDATE: begin
                    res  <= res_new;
                    sol  <= avg;
                    conv <= (mag <= {1'b0, TOL});
                end
                READ: sol <= {neighbor_solution, sol[W-1:1]};
                default: cnt <= '0;
            endcase
        end
    end

    assign solution = sol[0];
    assign residue  = res[0];
    assign busy     = (state == SUM) || (state == UPDATE);

endmodule

// File: tb/tb_pe_jacobi.sv
// Directed bench for pe_jacobi at W=8, NBR=4, TOL=0.
// A small solution/residue model tracks the expected serial outputs.
module tb_pe_jacobi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       read = 1'b0;
    logic [3:0] nbr_in = '0;
    logic       neighbor_solution = 1'b0;
    logic       solution;
    logic       residue;
    logic       busy;
    logic       done;
    logic       conv;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_sol = '0;
    logic [8:0] m_res = '0;
    logic       m_conv = 1'b0;

    pe_jacobi dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .read             (read),
        .nbr_in           (nbr_in),
        .neighbor_solution(neighbor_solution),
        .solution         (solution),
        .residue          (residue),
        .busy             (busy),
        .done             (done),
        .conv             (conv)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One READ cycle: observe, then shift ns in; stay selects read level.
    task automatic rd_bit(input logic ns, input logic stay);
        check("rd_sol", 16'(solution), 16'(m_sol[0]));
        check("rd_res", 16'(residue), 16'(m_res[0]));
        check("rd_conv", 16'(conv), 16'(m_conv));
        check("rd_busy", 16'(busy), 16'd0);
        neighbor_solution = ns;
        read = stay;
        step();
        m_sol = {ns, m_sol[7:1]};
    endtask

    task automatic load(input logic [7:0] v);
        read = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            rd_bit(v[i], (i < 7));
        end
        neighbor_solution = 1'b0;
    endtask

    task automatic run_iter(input logic [7:0] o0, input logic [7:0] o1,
                            input logic [7:0] o2, input logic [7:0] o3,
                            input logic hold);
        logic [7:0] ops [4];
        int         sum;
        logic [7:0] avg;
        logic [8:0] r;
        logic [8:0] mag;
        ops[0] = o0;
        ops[1] = o1;
        ops[2] = o2;
        ops[3] = o3;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                nbr_in[j] = (i < 8) ? ops[j][i] : 1'b0;
            end
            check("sum_busy", 16'(busy), 16'd1);
            check("sum_done", 16'(done), 16'd0);
            if (i < 8) check("sum_sol", 16'(solution), 16'(m_sol[i]));
            check("sum_res", 16'(residue), 16'(m_res[(i <= 8) ? i : 8]));
            step();
        end
        nbr_in = '0;
        check("upd_busy", 16'(busy), 16'd1);
        check("upd_done", 16'(done), 16'd0);
        step();
        start = 1'b0;
        sum = int'(o0) + int'(o1) + int'(o2) + int'(o3);
        avg = 8'(sum / 4);
        r = {1'b0, avg} - {1'b0, m_sol};
        mag = r[8] ? (9'd0 - r) : r;
        m_sol = avg;
        m_res = r;
        m_conv = (mag == 9'd0);
        check("done", 16'(done), 16'd1);
        check("done_busy", 16'(busy), 16'd0);
        check("conv", 16'(conv), 16'(m_conv));
        check("new_sol0", 16'(solution), 16'(m_sol[0]));
        check("new_res0", 16'(residue), 16'(m_res[0]));
        step();
        check("done_pulse", 16'(done), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_conv", 16'(conv), 16'd0);
        check("rst_sol", 16'(solution), 16'd0);
        check("rst_res", 16'(residue), 16'd0);

        // avg 100 from sol 0, then the same again to converge
        run_iter(8'd100, 8'd100, 8'd100, 8'd100, 1'b0);
        check("res_p100", 16'(m_res), 16'h064);
        run_iter(8'd100, 8'd100, 8'd100, 8'd100, 1'b0);
        check("conv_same", 16'(conv), 16'd1);
        run_iter(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        check("avg_255", 16'(m_sol), 16'h0ff);

        load(8'd0);
        run_iter(8'd3, 8'd0, 8'd0, 8'd0, 1'b0);
        check("trunc_conv", 16'(conv), 16'd1);
        load(8'd200);
        run_iter(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        check("res_m200", 16'(m_res), 16'h138);
        run_iter(8'd7, 8'd9, 8'd20, 8'd1, 1'b0);

        // serial 0xA5 in through the chain, then out on solution
        read = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            rd_bit(((8'hA5 >> i) & 8'h1) != 0, 1'b1);
        end
        check("chain_a5", 16'(m_sol), 16'h0a5);
        for (int i = 0; i < 8; i++) begin
            rd_bit(1'b0, (i < 7));
        end

        load(8'd60);
        start = 1'b1;
        step();
        start = 1'b0;
        nbr_in = 4'hF;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nbr_in = '0;
        m_sol = '0;
        m_res = '0;
        m_conv = 1'b0;
        check("mid_busy", 16'(busy), 16'd0);
        check("mid_done", 16'(done), 16'd0);
        check("mid_sol", 16'(solution), 16'd0);
        check("mid_res", 16'(residue), 16'd0);
        check("mid_conv", 16'(conv), 16'd0);
        run_iter(8'd4, 8'd8, 8'd12, 8'd16, 1'b0);

        run_iter(8'd50, 8'd51, 8'd52, 8'd53, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("one_done", 16'(done), 16'd0);
            check("one_busy", 16'(busy), 16'd0);
            step();
        end

        read = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_bit(i[0], (i < 7));
        end
        check("prio_sol", 16'(m_sol), 16'h0aa);
        run_iter(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_jacobi.md
PE_JACOBI -- requirements
Module: pe_jacobi

Interface
REQ-001 SHALL have parameter W, default 8: solution word width in bits, legal range 4..16.
REQ-002 SHALL have parameter NBR, default 4: neighbour count, power of two, 2..8; localparam SH = log2(NBR).
REQ-003 SHALL have parameter TOL, default 0: convergence threshold, unsigned W bits.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request one Jacobi iteration; level-sampled in IDLE only.
REQ-007 SHALL have port read  in  1  readout/load mode; daisy-chain shift of the solution word.
REQ-008 SHALL have port nbr_in  in  NBR  neighbour solution bits, serial LSB-first, one bit per lane per SUM cycle.
REQ-009 SHALL have port neighbor_solution  in  1  chain input shifted into the solution MSB in READ.
REQ-010 SHALL have port solution  out  1  serial solution bit, LSB-first.
REQ-011 SHALL have port residue  out  1  serial residue bit, LSB-first, two's complement.
REQ-012 SHALL have port busy  out  1  high in SUM and UPDATE.
REQ-013 SHALL have port done  out  1  one-cycle pulse when an iteration result is committed.
REQ-014 SHALL have port conv  out  1  high when |last residue| <= TOL.

Function
REQ-015 SHALL implement states IDLE, SUM, UPDATE, READ.
REQ-016 IDLE: read=1 -> READ; else start=1 -> SUM with bit counter 0; read has priority over start.
REQ-017 SUM SHALL last W+SH cycles. In cycle i<W each nbr_in lane carries operand bit i. In cycles i>=W the lanes are treated as 0 to flush carries.
REQ-018 SUM SHALL compute the exact unsigned sum of NBR W-bit operands. It uses one serial adder column with registered multi-bit carry (width SH+1) and captures one sum bit per cycle into a (W+SH)-bit register, filled LSB-first.
REQ-019 Average SHALL be sum[W+SH-1:SH] (truncating divide by NBR); no overflow is possible.
REQ-020 In SUM cycles i<W, solution SHALL equal sol[i]. The solution register rotates right once per such cycle and is restored unchanged at the end of SUM. solution is frozen during the flush cycles.
REQ-021 In SUM cycles i<=W, residue SHALL equal bit i of the stored (W+1)-bit residue, via an arithmetic right shift. It holds the sign bit thereafter.
REQ-022 UPDATE SHALL last 1 cycle: res <= avg - sol_old as (W+1)-bit two's complement; sol <= avg; conv <= (|res_new| <= TOL); next state IDLE.
REQ-023 done SHALL be high exactly in the cycle after UPDATE, with new sol, res and conv already visible.
REQ-024 Latency: start sampled at edge k -> busy high from cycle k+1 -> done high in cycle k+W+SH+2.
REQ-025 READ: each cycle sol <= {neighbor_solution, sol[W-1:1]}, and solution = sol[0]. When read=0 is sampled, return to IDLE. res and conv are unchanged.
REQ-026 start SHALL be ignored in SUM, UPDATE and READ; read SHALL be ignored in SUM and UPDATE. Neither is queued.
REQ-027 The initial solution SHALL be loaded only through the READ chain; there is no parallel load.

Reset
REQ-028 rst=1 at any edge, including mid-SUM or mid-READ, SHALL force IDLE and clear sol, res, the sum register, the carries and the counter. The next cycle then shows busy=0, done=0, conv=0, solution=0, residue=0.
REQ-029 rst SHALL take priority over start and read in the same cycle.

Structure
REQ-030 A shared package pe_pkg SHALL hold the state enum and the log2 helper function used for SH.
REQ-031 The serial adder column SHALL be a sub-module serial_sum (parameters NBR and SH; ports clk, rst, clr, en, bits[NBR], sum_bit). All other logic stays in pe_jacobi.
REQ-032 Target size: 150-300 lines of RTL total.

Verification (W=8, NBR=4, TOL=0 unless stated)
REQ-033 sol=0, all lanes 100 -> sum 400, avg 100; sol=100, res=+100, conv=0, done in cycle k+12.
REQ-034 Repeat the iteration with the same inputs -> res=0, conv=1; all lanes 255 -> avg 255 with no wrap.
REQ-035 Lanes 3,0,0,0 from sol=0 -> avg 0 (truncation), res=0; lanes 0 from sol=200 -> res=-200 (9'h138), conv=0.
REQ-036 READ with chain bits 1,0,1,0,0,1,0,1 (serial 0xA5 LSB-first) -> sol=0xA5; the next 8 READ cycles output 1,0,1,0,0,1,0,1 on solution.
REQ-037 rst asserted in SUM cycle 5 -> next cycle IDLE, busy=0, sol=0; a following start completes normally.
REQ-038 start held high through UPDATE -> exactly one done per sampled start in IDLE; read and start both high in IDLE -> READ is entered.
